fp_minmax_cmp_stream: RTL

- Parametrised, pipelined IEEE-754 sign/compare/select unit with AXI-stream valid/ready handshake on input and output.
- Successor to the single-precision combinational abs wrapper: generic exponent/mantissa width, eight run-time opcodes, configurable pipeline depth, backpressure, and an exception flag.
- Sits beside the add/mul/div/sqrt wrappers in the floating-point datapath and feeds the same result bus.

---
 rtl/fp_minmax_cmp_stream.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fp_minmax_cmp_stream.sv
// fp_minmax_cmp_stream
// Pipelined IEEE-754 sign/compare/select unit with valid/ready handshake on
// both sides. The result is computed combinationally from the input beat and
// then travels through LATENCY register stages that all advance together.
// Supported ops: ABS, NEG, MIN, MAX, CMP_EQ, CMP_LT, CMP_LE, COPYSIGN.
// Each result carries the IEEE invalid-operation flag alongside it.

module fp_minmax_cmp_stream #(
  parameter  int EXP_W   = 8,
  parameter  int MAN_W   = 23,
  parameter  int LATENCY = 2,
  localparam int W       = 1 + EXP_W + MAN_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] s_axis_a_tdata,
  input  logic [W-1:0] s_axis_b_tdata,
  input  logic [2:0]   s_axis_op_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [W-1:0] m_axis_result_tdata,
  output logic         m_axis_result_invalid,
  output logic         m_axis_result_tvalid,
  input  logic         m_axis_result_tready
);

  typedef enum logic [2:0] {
    OP_ABS      = 3'd0,
    OP_NEG      = 3'd1,
    OP_MIN      = 3'd2,
    OP_MAX      = 3'd3,
    OP_CMP_EQ   = 3'd4,
    OP_CMP_LT   = 3'd5,
    OP_CMP_LE   = 3'd6,
    OP_COPYSIGN = 3'd7
  } op_e;

  // Canonical quiet NaN: positive, all-ones exponent, only the quiet bit set.
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Pipeline stage storage; index LATENCY-1 drives the output.
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] inv_q;
  logic [W-1:0]       data_q [LATENCY];

  logic         adv;
  logic         accept;
  logic [W-1:0] res;
  logic         res_inv;

  // Operand fields and classes.
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp,  b_exp;
  logic [MAN_W-1:0]   a_man,  b_man;
  logic               a_nan,  b_nan;
  logic               a_snan, b_snan;
  logic               a_zero, b_zero;
  logic               any_nan, any_snan, both_zero;
  logic               lt_total, ord_lt, ord_eq;

  // Whole pipeline moves when the output slot is empty or being drained.
  always_comb begin
    adv           = m_axis_result_tready | ~m_axis_result_tvalid;
    s_axis_tready = adv;
    accept        = s_axis_tvalid & adv;
  end

  // Classify both operands and derive the ordered relations.
  always_comb begin
    a_sign = s_axis_a_tdata[W-1];
    b_sign = s_axis_b_tdata[W-1];
    a_exp  = s_axis_a_tdata[W-2:MAN_W];
    b_exp  = s_axis_b_tdata[W-2:MAN_W];
    a_man  = s_axis_a_tdata[MAN_W-1:0];
    b_man  = s_axis_b_tdata[MAN_W-1:0];

    a_nan  = (&a_exp) & (|a_man);
    b_nan  = (&b_exp) & (|b_man);
    a_snan = a_nan & ~a_man[MAN_W-1];
    b_snan = b_nan & ~b_man[MAN_W-1];
    a_zero = ~(|a_exp) & ~(|a_man);
    b_zero = ~(|b_exp) & ~(|b_man);

    any_nan   = a_nan | b_nan;
    any_snan  = a_snan | b_snan;
    both_zero = a_zero & b_zero;

    // Sign-magnitude total order on non-NaN values with -0 below +0.
    // Denormals need no special case: magnitude order is the integer order.
    if (a_sign != b_sign)
      lt_total = a_sign;
    else if (a_sign)
      lt_total = s_axis_a_tdata[W-2:0] > s_axis_b_tdata[W-2:0];
    else
      lt_total = s_axis_a_tdata[W-2:0] < s_axis_b_tdata[W-2:0];

    // Comparison ops treat the two zeros as equal.
    ord_lt = lt_total & ~both_zero;
    ord_eq = (s_axis_a_tdata == s_axis_b_tdata) | both_zero;
  end

  // Select the result and invalid flag for the requested op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case so that no path leaves it unassigned and a latch is never inferred.
    res     = '0;
    res_inv = 1'b0;
    case (op_e'(s_axis_op_tdata))
      OP_ABS:      res = {1'b0, s_axis_a_tdata[W-2:0]};
      OP_NEG:      res = {~a_sign, s_axis_a_tdata[W-2:0]};
      OP_COPYSIGN: res = {b_sign, s_axis_a_tdata[W-2:0]};
      OP_MIN, OP_MAX: begin
        res_inv = any_snan;
        if (a_nan & b_nan)
          res = QNAN;
        else if (a_nan)
          res = s_axis_b_tdata;
        else if (b_nan)
          res = s_axis_a_tdata;
        else if (lt_total ^ (s_axis_op_tdata == OP_MAX))
          res = s_axis_a_tdata;
        else
          res = s_axis_b_tdata;
      end
      OP_CMP_EQ: begin
        res     = {{(W-1){1'b0}}, ord_eq & ~any_nan};
        res_inv = any_snan;
      end
      OP_CMP_LT: begin
        res     = {{(W-1){1'b0}}, ord_lt & ~any_nan};
        res_inv = any_nan;
      end
      OP_CMP_LE: begin
        res     = {{(W-1){1'b0}}, (ord_lt | ord_eq) & ~any_nan};
        res_inv = any_nan;
      end
      default: ;
    endcase
  end

  // Pipeline stages: load stage 0 from the compute logic, shift the rest.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
      inv_q <= '0;
      // NOTE: the data stages are reset too, not just the valid bits, because
      // the output bus must read zero while the unit is held in reset.
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, so the loop order does not matter.
      vld_q[0]  <= accept;
      inv_q[0]  <= res_inv;
      data_q[0] <= res;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        inv_q[i]  <= inv_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Output is the last stage; it holds while stalled because adv is low.
  always_comb begin
    m_axis_result_tvalid  = vld_q[LATENCY-1];
    m_axis_result_invalid = inv_q[LATENCY-1];
    m_axis_result_tdata   = data_q[LATENCY-1];
  end

endmodule
